// File: rtl/fibonacci_index_finder.sv
// Inverse Fibonacci: walks F(1)=1, F(2)=1, ... until it meets, passes or overflows the target.
// Optional cycle counter output enabled by defining FIB_INDEX_CYCLE_CTR_EN.
module fibonacci_index_finder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fibo_in,
  input  logic             begin_fibo,
  output logic             done,
  output logic [IDX_W-1:0] index_out,
  output logic             found,
`ifdef FIB_INDEX_CYCLE_CTR_EN
  output logic [5:0]       cycles_out,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: begin_fibo is a one-cycle request, accepted only in IDLE or DONE
  // (ignored in CALC); done stays high with index_out/found stable until the next
  // accepted request or reset.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] a;
  logic [WIDTH:0]   b;
  logic [IDX_W-1:0] idx;
  logic             accept;

  assign accept    = begin_fibo && (state == IDLE || state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      index_out <= '0;
      found     <= 1'b0;
      target    <= '0;
      a         <= '0;
      b         <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (begin_fibo) begin
            target    <= fibo_in;
            a         <= WIDTH'(1);
            b         <= (WIDTH+1)'(1);
            idx       <= IDX_W'(1);
            done      <= 1'b0;
            index_out <= '0;
            found     <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          if (a == target) begin
            found     <= 1'b1;
            index_out <= idx;
            done      <= 1'b1;
            state     <= DONE;
          end else if (a > target) begin
            found     <= 1'b0;
            index_out <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (b[WIDTH]) begin
            // Next term no longer fits, so the target lies beyond the largest term.
            found     <= 1'b0;
            index_out <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            a   <= b[WIDTH-1:0];
            b   <= {1'b0, a} + b;
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIB_INDEX_CYCLE_CTR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_out <= '0;
    end else if (accept) begin
      cycles_out <= '0;
    end else if (state == CALC) begin
      cycles_out <= cycles_out + 6'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// Directed bench for fibonacci_index_finder: driver pushes expected results, monitor checks on done.
module tb_fibonacci_index_finder;

  logic        clk;
  logic        reset;
  logic [15:0] fibo_in;
  logic        begin_fibo;
  logic        done;
  logic [4:0]  index_out;
  logic        found;
  logic [1:0]  state_dbg;
`ifdef FIB_INDEX_CYCLE_CTR_EN
  logic [5:0]  cycles_out;
`endif

  // Expected entry: {latency[5:0], found, index[4:0]}
  logic [11:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  logic        done_prev = 1'b0;

  fibonacci_index_finder #(.WIDTH(16), .IDX_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .fibo_in    (fibo_in),
    .begin_fibo (begin_fibo),
    .done       (done),
    .index_out  (index_out),
    .found      (found),
`ifdef FIB_INDEX_CYCLE_CTR_EN
    .cycles_out (cycles_out),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard: compares on every rising edge of done
  initial begin
    logic [11:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (!reset && done && !done_prev) begin
        lat = cyc - issue_cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("index_out", int'(index_out), int'(e[4:0]));
          check("found", int'(found), int'(e[5]));
          check("latency", lat, int'(e[11:6]));
`ifdef FIB_INDEX_CYCLE_CTR_EN
          check("cycles_out", int'(cycles_out), int'(e[11:6]));
`endif
        end
      end
      done_prev = done;
    end
  end

  // Driver tasks
  task automatic issue(input logic [15:0] v, input bit check_drop);
    @(negedge clk);
    fibo_in    = v;
    begin_fibo = 1'b1;
    @(posedge clk);
    #1;
    issue_cyc  = cyc;
    begin_fibo = 1'b0;
    if (check_drop) begin
      check("drop_done", int'(done), 0);
      check("drop_index", int'(index_out), 0);
      check("drop_found", int'(found), 0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", 1, 0);
      exp_q.delete();
    end
  endtask

  task automatic run_req(input logic [15:0] v, input logic [4:0] ei, input logic ef,
                         input int el, input bit check_drop);
    exp_q.push_back({6'(el), ef, ei});
    issue(v, check_drop);
    wait_drain();
    @(negedge clk);
    check("hold_done", int'(done), 1);
    check("hold_index", int'(index_out), int'(ei));
  endtask

  logic [15:0] fib_tab [1:24] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                                  16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610,
                                  16'd987, 16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946,
                                  16'd17711, 16'd28657, 16'd46368};

  initial begin
    int ei;
    reset      = 1'b1;
    fibo_in    = '0;
    begin_fibo = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_index", int'(index_out), 0);
    check("reset_found", int'(found), 0);
    check("reset_state", int'(state_dbg), 0);
    reset = 1'b0;

    // 1..4: basic matches, non-members, zero, overflow exit
    run_req(16'd1, 5'd1, 1'b1, 1, 1'b0);
    run_req(16'd46368, 5'd24, 1'b1, 24, 1'b0);
    run_req(16'd55, 5'd10, 1'b1, 10, 1'b1);
    run_req(16'd4, 5'd0, 1'b0, 5, 1'b0);
    run_req(16'd0, 5'd0, 1'b0, 1, 1'b0);
    run_req(16'd65535, 5'd0, 1'b0, 24, 1'b0);
    run_req(16'd46369, 5'd0, 1'b0, 24, 1'b0);
    run_req(16'd100, 5'd0, 1'b0, 12, 1'b0);

    // 5: ignored re-request in CALC, then reset mid-calculation
    issue(16'd6765, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    fibo_in    = 16'd1;
    begin_fibo = 1'b1;
    @(posedge clk);
    #1;
    begin_fibo = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("calc_busy_done", int'(done), 0);
    check("calc_state", int'(state_dbg), 1);
    reset = 1'b1;
    #1;
    check("midreset_done", int'(done), 0);
    check("midreset_index", int'(index_out), 0);
    check("midreset_state", int'(state_dbg), 0);
    @(negedge clk);
    reset = 1'b0;
    run_req(16'd6765, 5'd20, 1'b1, 20, 1'b0);

    // Reset while in DONE
    reset = 1'b1;
    #1;
    check("donereset_done", int'(done), 0);
    check("donereset_found", int'(found), 0);
    @(negedge clk);
    reset = 1'b0;

    // 6: loopback over every term F(1)..F(24)
    for (int n = 1; n <= 24; n++) begin
      ei = (n == 2) ? 1 : n;
      run_req(fib_tab[n], 5'(ei), 1'b1, ei, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fibonacci_index_finder.md
Name: fibonacci_index_finder

Overview:
- Inverse of the Fibonacci calculator: accepts a 16-bit value and returns the index n where F(n) equals it, or flags that no such n exists.
- Uses the same request/done handshake as the calculator, so a checker or loopback bench can chain calculator output into this block and recover the original index.
- Sequence convention is fixed: F(1)=1, F(2)=1, F(3)=2, ..., F(24)=46368 (largest term that fits in 16 bits).

Parameters:
- WIDTH, 16, bit width of the value input and the internal Fibonacci terms.
- IDX_W, 5, bit width of the index output.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE immediately.
- fibo_in  input  WIDTH  value to invert; sampled only on an accepted begin_fibo.
- begin_fibo  input  1  request strobe, one cycle; accepted in IDLE or DONE.
- done  output  1  high while the result is valid (DONE state).
- index_out  output  IDX_W  matching index n; 0 when not found.
- found  output  1  1 if fibo_in is a Fibonacci term, else 0.

Behaviour:
- Reset (async assert): state=IDLE, done=0, index_out=0, found=0, internal a/b/idx/target cleared.
- State IDLE: on begin_fibo=1, latch target<=fibo_in, a<=1, b<=1 (WIDTH+1 bits, includes carry), idx<=1, go to CALC.
- State CALC (one comparison per cycle):
  - a==target: found<=1, index_out<=idx, go DONE.
  - a>target: found<=0, index_out<=0, go DONE.
  - a<target and b[WIDTH]==1 (next term overflowed): found<=0, index_out<=0, go DONE.
  - Otherwise: a<=b[WIDTH-1:0], b<=a+b (WIDTH+1-bit sum), idx<=idx+1.
  - begin_fibo is ignored in CALC.
- State DONE: done=1, outputs held stable. begin_fibo=1 restarts exactly as from IDLE: done falls at that edge and index_out/found clear to 0.
- Latency, counted in rising edges after the edge that samples begin_fibo:
  - Match at index k: done visible after edge k (F(1)=1 gives 1 cycle; F(24) gives 24 cycles).
  - Non-member v with F(k-1)<v<F(k): k cycles.
  - v=0: 1 cycle.
  - v>46368: 24 cycles, via the overflow exit.
- Ambiguity rule: value 1 matches F(1) and F(2); the block returns the smallest index, 1.
- idx never exceeds 24 for WIDTH=16, so it cannot wrap IDX_W.
- Reset asserted mid-CALC or in DONE: immediate return to IDLE, all outputs 0, in-flight request discarded.

Optional Feature:
- Macro: FIB_INDEX_CYCLE_CTR_EN.
- Defined:
  - Adds output cycles_out[5:0], cleared to 0 on reset and on each accepted begin_fibo.
  - Increments on every CALC-state edge, frozen in DONE. It therefore equals the latency figures above, e.g. 24 for input 46368.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset, then fibo_in=1 with one-cycle begin_fibo -> done after 1 edge, found=1, index_out=1.
2. fibo_in=46368 -> done after 24 edges, found=1, index_out=24. Then fibo_in=55 issued in DONE -> done drops at that edge, returns index_out=10 after 10 edges.
3. fibo_in=4 -> done after 5 edges, found=0, index_out=0. Then fibo_in=0 -> done after 1 edge, found=0.
4. fibo_in=65535 -> overflow exit, done after 24 edges, found=0, index_out=0, no wrap of idx.
5. fibo_in=6765: pulse begin_fibo again at edge 3 (ignored), then assert reset at edge 10 -> done=0, index_out=0 immediately. Re-request 6765 -> index_out=20 after 20 edges.
6. Loopback with fibonacci_calculator for input_s=1..24: feed its fibo_out into this block -> index_out==input_s for all except input_s=2, which returns 1; found=1 throughout.
